vram_writer: RTL and testbench

Write-side engine for the XERA4 video RAM: the 32 KB, 320x200x4-bit framebuffer plus ink table that the video chip scans out. It accepts plot, ink-write and clear-screen commands from the CPU side over a valid/ready handshake. It drives the write/read port of the dual-port video RAM, doing nibble read-modify-write for single pixels. The video chip keeps the other port.

---
 rtl/vram_writer.sv | 175 +++++++++++++++++
 tb/tb_vram_writer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_writer.sv
// vram_writer -- write-side engine for the XERA4 video RAM.
//
// Accepts plot / ink-write / clear-screen commands from the CPU side over a
// valid/ready handshake and drives the write/read port of the dual-port
// video RAM. The video chip owns the other port.
//
// Memory map (fixed geometry, 320x200x4bpp, 160 bytes per line):
//   0x0000-0x7CFF  pixels, even x in [7:4], odd x in [3:0]
//   0x7D00-0x7D1F  16 inks, two bytes each: {G,B} then {0,R}
//
// Ports:
//   clk, reset            system clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready   command handshake, ready only while idle
//   cmd_op                00 plot, 01 ink write, 10 clear, 11 reserved
//   cmd_x, cmd_y          pixel coordinate (cmd_x[3:0] = ink index)
//   cmd_data              [3:0] pixel value, [11:0] RGB 4:4:4 for inks
//   done, err             one-cycle completion / rejection pulses
//   ram_add/wdata/we      RAM port, decoded from registered state only
//   ram_rdata             RAM read data, one cycle after the address
module vram_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [11:0] cmd_data,
  output logic        done,
  output logic        err,
  output logic [14:0] ram_add,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata
);

  typedef enum logic [2:0] {
    IDLE, P_RD, P_CAP, P_WR, I_LO, I_HI, CLR, REJ
  } state_t;

  typedef struct packed {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] data;
  } cmd_t;

  localparam logic [1:0]  OP_PLOT  = 2'b00;
  localparam logic [1:0]  OP_INK   = 2'b01;
  localparam logic [1:0]  OP_CLR   = 2'b10;
  localparam logic [14:0] PIX_LAST = 15'h7CFF;
  localparam logic [14:0] INK_BASE = 15'h7D00;

  state_t      state, state_nx;
  cmd_t        cmd_r;
  logic [7:0]  rd_r;      // byte fetched for nibble read-modify-write
  logic [14:0] clr_cnt;   // clear address, stops at PIX_LAST
  logic        done_r, done_nx;
  logic        accept;
  logic        in_range;
  logic [14:0] pix_add;
  logic [14:0] ink_add;
  logic [7:0]  plot_byte;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign in_range  = (cmd_x < 9'd320) && (cmd_y < 8'd200);
  assign done      = done_r;
  // REJ lasts exactly one cycle, so the state itself is the err pulse.
  assign err       = (state == REJ);

  // y*160 = y*128 + y*32, plus x/2; maximum 31999 fits in 15 bits.
  assign pix_add = {cmd_r.y, 7'b0} + {2'b0, cmd_r.y, 5'b0} + {7'b0, cmd_r.x[8:1]};
  // Ink base has five zero LSBs, so the index just ORs in.
  assign ink_add = INK_BASE | {10'b0, cmd_r.x[3:0], 1'b0};

  // Even x owns the high nibble.
  assign plot_byte = cmd_r.x[0] ? {rd_r[7:4], cmd_r.data[3:0]}
                                : {cmd_r.data[3:0], rd_r[3:0]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and done strobe
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_PLOT: state_nx = in_range ? P_RD : REJ;
            OP_INK:  state_nx = I_LO;
            OP_CLR:  state_nx = CLR;
            default: state_nx = REJ;
          endcase
        end
      end
      P_RD:  state_nx = P_CAP;
      P_CAP: state_nx = P_WR;
      P_WR: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      I_LO:  state_nx = I_HI;
      I_HI: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      CLR: begin
        if (clr_cnt == PIX_LAST) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      REJ:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command capture, read latch, clear counter, done register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_r   <= '0;
      rd_r    <= '0;
      clr_cnt <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= done_nx;
      if (accept) begin
        cmd_r   <= '{x: cmd_x, y: cmd_y, data: cmd_data};
        clr_cnt <= '0;
      end else if (state == CLR) begin
        // wrap to zero on the final byte so the count never enters ink space
        clr_cnt <= (clr_cnt == PIX_LAST) ? '0 : clr_cnt + 15'd1;
      end
      // RAM sampled the address at the end of P_RD; data is valid now.
      if (state == P_CAP) rd_r <= ram_rdata;
    end
  end

  // RAM port decode: depends only on registered state and captured command
  always_comb begin
    ram_add   = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    unique case (state)
      P_RD: ram_add = pix_add;
      P_WR: begin
        ram_add   = pix_add;
        ram_wdata = plot_byte;
        ram_we    = 1'b1;
      end
      I_LO: begin
        ram_add   = ink_add;
        ram_wdata = cmd_r.data[7:0];
        ram_we    = 1'b1;
      end
      I_HI: begin
        ram_add   = ink_add | 15'd1;
        ram_wdata = {4'h0, cmd_r.data[11:8]};
        ram_we    = 1'b1;
      end
      CLR: begin
        ram_add   = clr_cnt;
        ram_wdata = {cmd_r.data[3:0], cmd_r.data[3:0]};
        ram_we    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vram_writer.sv
// Scoreboard bench for vram_writer: stimulus tasks push expected RAM writes,
// done and err events (with the cycle they must appear in) into a queue; a
// negedge monitor pops and compares every event the DUT presents.
module tb_vram_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [11:0] cmd_data;
  logic        done, err;
  logic [14:0] ram_add;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  vram_writer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_data(cmd_data),
    .done(done), .err(err),
    .ram_add(ram_add), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous RAM model
  logic [7:0] mem [0:32767];
  always @(posedge clk) begin
    if (ram_we) mem[ram_add] <= ram_wdata;
    ram_rdata <= mem[ram_add];
  end

  localparam int K_W = 0, K_DONE = 1, K_ERR = 2;
  typedef struct {
    int          kind;
    logic [14:0] a;
    logic [7:0]  d;
    int          cyc;
  } ev_t;
  ev_t exp_q[$];

  int tests = 0;
  int fails = 0;

  task automatic push(input int kind, input logic [14:0] a, input logic [7:0] d, input int c);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_evt(input int kind, input logic [14:0] a, input logic [7:0] d);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: kind %0d add %0h data %0h at cyc %0d, none expected",
               kind, a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == K_W && (e.a != a || e.d != d))) begin
        fails++;
        if (fails <= 20)
          $display("FAIL event: got kind %0d add %0h data %0h cyc %0d, want kind %0d add %0h data %0h cyc %0d",
                   kind, a, d, cyc, e.kind, e.a, e.d, e.cyc);
      end
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (done && err) chk("done_err_together", 1, 0);
      if (ram_we) check_evt(K_W, ram_add, ram_wdata);
      if (done)   check_evt(K_DONE, '0, '0);
      if (err)    check_evt(K_ERR, '0, '0);
    end
  end

  // Present a command at a negedge and wait for ready; t = accept edge cycle.
  task automatic accept(input logic [1:0] op, input logic [8:0] x, input logic [7:0] y,
                        input logic [11:0] d, output int t);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_data = d;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", int'(cmd_ready), 1);
    t = cyc + 1;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic plot(input logic [8:0] x, input logic [7:0] y, input logic [3:0] v,
                      input logic [14:0] ea, input logic [7:0] ed, output int t);
    accept(2'b00, x, y, {8'h0, v}, t);
    push(K_W, ea, ed, t + 2);
    push(K_DONE, '0, '0, t + 3);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("plot_rd_add", int'(ram_add), int'(ea));
    chk("plot_rd_we", int'(ram_we), 0);
  endtask

  task automatic rej(input logic [1:0] op, input logic [8:0] x, input logic [7:0] y, input bit hold);
    int t;
    accept(op, x, y, 12'h000, t);
    push(K_ERR, '0, '0, t);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    chk("rej_we", int'(ram_we), 0);
    chk("rej_ready", int'(cmd_ready), 0);
  endtask

  task automatic ink(input logic [3:0] idx, input logic [11:0] rgb,
                     input logic [14:0] ea, input logic [7:0] lo, input logic [7:0] hi);
    int t;
    accept(2'b01, {5'b0, idx}, 8'h00, rgb, t);
    push(K_W, ea, lo, t);
    push(K_W, ea + 15'd1, hi, t + 1);
    push(K_DONE, '0, '0, t + 2);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int t1, t2, tc;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_data = '0;
    mem[15'h0000] <= 8'h55;
    mem[15'h0001] <= 8'h81;
    mem[15'h00A0] <= 8'h3C;
    mem[15'h7CFF] <= 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_add", int'(ram_add), 0);
    chk("rst_wdata", int'(ram_wdata), 0);
    reset = 1'b0;
    @(negedge clk);

    plot(9'd0, 8'd0, 4'hA, 15'h0000, 8'hA5, t1);       drain(20);
    plot(9'd319, 8'd199, 4'h3, 15'h7CFF, 8'hF3, t1);   drain(20);
    rej(2'b00, 9'd320, 8'd0, 1'b0);                    drain(20);
    rej(2'b00, 9'd5, 8'd200, 1'b0);                    drain(20);

    // back-to-back plots, 4 cycles apart
    plot(9'd1, 8'd1, 4'h6, 15'h00A0, 8'h36, t1);
    plot(9'd2, 8'd0, 4'hC, 15'h0001, 8'hC1, t2);
    chk("b2b_spacing", t2 - t1, 4);
    drain(20);

    ink(4'd15, 12'hF0A, 15'h7D1E, 8'h0A, 8'h0F);       drain(20);

    // full clear
    accept(2'b10, 9'd0, 8'd0, 12'h007, tc);
    for (int i = 0; i < 32000; i++) push(K_W, 15'(i), 8'h77, tc + i);
    push(K_DONE, '0, '0, tc + 32000);
    @(negedge clk);
    cmd_valid = 1'b0;
    drain(33000);
    chk("clr_first", int'(mem[15'h0000]), 8'h77);
    chk("clr_last", int'(mem[15'h7CFF]), 8'h77);
    chk("ink_lo_kept", int'(mem[15'h7D1E]), 8'h0A);
    chk("ink_hi_kept", int'(mem[15'h7D1F]), 8'h0F);

    // held valid: reserved op rejected, then plot taken on next idle edge
    rej(2'b11, 9'd0, 8'd0, 1'b1);
    plot(9'd4, 8'd2, 4'h1, 15'h0142, 8'h17, t1);
    drain(20);

    // reset during clear at cycle 100
    accept(2'b10, 9'd0, 8'd0, 12'h002, tc);
    for (int i = 0; i < 100; i++) push(K_W, 15'(i), 8'h22, tc + i);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (99) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_we", int'(ram_we), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_writes_seen", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    chk("abort_ready_after", int'(cmd_ready), 1);

    // engine still works; byte 1 holds 0x22 from the partial clear
    plot(9'd3, 8'd0, 4'h9, 15'h0001, 8'h29, t1);
    drain(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
